// File: rtl/core_branch_unit.sv
// core_branch_unit: resolves conditional branches, JAL and JALR.
// It computes taken/target/link/redirect, detects mispredictions,
// misaligned targets and illegal branch encodings, and holds the result
// in one registered output stage with a ready/valid handshake. It also
// keeps two saturating performance counters.
module core_branch_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [1:0]       IN_TYPE,
   input  logic [2:0]       FUNCT3,
   input  logic [XLEN-1:0]  RS1,
   input  logic [XLEN-1:0]  RS2,
   input  logic [XLEN-1:0]  PC,
   input  logic [XLEN-1:0]  IMM,
   input  logic             PRED_TAKEN,
   input  logic [XLEN-1:0]  PRED_TARGET,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             OUT_TAKEN,
   output logic [XLEN-1:0]  OUT_TARGET,
   output logic [XLEN-1:0]  OUT_LINK,
   output logic [XLEN-1:0]  OUT_REDIRECT,
   output logic             OUT_MISPREDICT,
   output logic             OUT_MISALIGNED,
   output logic             OUT_ILLEGAL,
   input  logic             CNT_CLR,
   output logic [CNT_W-1:0] BR_COUNT,
   output logic [CNT_W-1:0] MISPRED_COUNT
);

   localparam logic [1:0] TYPE_NOP  = 2'b00;
   localparam logic [1:0] TYPE_BR   = 2'b01;
   localparam logic [1:0] TYPE_JAL  = 2'b10;
   localparam logic [1:0] TYPE_JALR = 2'b11;

   // Evaluate a branch condition from the precomputed compare flags.
   // The encodings 010 and 011 are not valid conditions, so they give 0.
   function automatic logic f_branch_cond(
      input logic [2:0] funct3,
      input logic       eq,
      input logic       slt,
      input logic       ult
   );
      logic res;
      case (funct3)
         3'b000:  res = eq;
         3'b001:  res = ~eq;
         3'b100:  res = slt;
         3'b101:  res = ~slt;
         3'b110:  res = ult;
         3'b111:  res = ~ult;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Add one to a counter value. An all-ones value stays at all-ones.
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] res;
      if (&value) begin
         res = value;
      end else begin
         res = value + CNT_W'(1);
      end
      return res;
   endfunction

   logic             r_valid;
   logic             r_taken;
   logic [XLEN-1:0]  r_target;
   logic [XLEN-1:0]  r_link;
   logic [XLEN-1:0]  r_redirect;
   logic             r_mispred;
   logic             r_misaligned;
   logic             r_illegal;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_mp_cnt;

   logic             w_eq;
   logic             w_slt;
   logic             w_ult;
   logic             w_illegal;
   logic             w_taken;
   logic [XLEN-1:0]  w_pc_sum;
   logic [XLEN-1:0]  w_rs_sum;
   logic [XLEN-1:0]  w_target;
   logic [XLEN-1:0]  w_link;
   logic [XLEN-1:0]  w_redirect;
   logic             w_mispred;
   logic             w_misaligned;
   logic             w_accept;
   logic             w_is_cf;

   // The stage can take new data when it is empty or is being drained this cycle.
   assign IN_READY = ~r_valid | OUT_READY;
   assign w_accept = IN_VALID & IN_READY & ~FLUSH;
   assign w_is_cf  = (IN_TYPE != TYPE_NOP);

   // Resolve the request combinationally from the current inputs.
   always_comb begin
      w_eq      = (RS1 == RS2);
      w_slt     = ($signed(RS1) < $signed(RS2));
      w_ult     = (RS1 < RS2);
      w_illegal = (IN_TYPE == TYPE_BR) &&
                  ((FUNCT3 == 3'b010) || (FUNCT3 == 3'b011));
      w_pc_sum  = PC + IMM;
      w_rs_sum  = RS1 + IMM;
      w_link    = PC + XLEN'(4);

      case (IN_TYPE)
         TYPE_BR:   w_taken = f_branch_cond(FUNCT3, w_eq, w_slt, w_ult) & ~w_illegal;
         TYPE_JAL:  w_taken = 1'b1;
         TYPE_JALR: w_taken = 1'b1;
         default:   w_taken = 1'b0;
      endcase

      // JALR clears bit 0 of the target. The other types use PC+IMM.
      if (IN_TYPE == TYPE_JALR) begin
         w_target = w_rs_sum & {{(XLEN-1){1'b1}}, 1'b0};
      end else begin
         w_target = w_pc_sum;
      end

      if (w_taken) begin
         w_redirect = w_target;
      end else begin
         w_redirect = w_link;
      end

      if (w_is_cf) begin
         w_mispred = (w_taken != PRED_TAKEN) || (w_taken && (w_target != PRED_TARGET));
      end else begin
         w_mispred = 1'b0;
      end

      w_misaligned = w_taken && (w_target[1:0] != 2'b00);
   end

   // Output stage: load on acceptance, empty on flush or on a drain with no new data.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_valid      <= 1'b0;
         r_taken      <= 1'b0;
         r_target     <= '0;
         r_link       <= '0;
         r_redirect   <= '0;
         r_mispred    <= 1'b0;
         r_misaligned <= 1'b0;
         r_illegal    <= 1'b0;
      end else if (FLUSH) begin
         r_valid      <= 1'b0;
      end else if (w_accept) begin
         r_valid      <= 1'b1;
         r_taken      <= w_taken;
         r_target     <= w_target;
         r_link       <= w_link;
         r_redirect   <= w_redirect;
         r_mispred    <= w_mispred;
         r_misaligned <= w_misaligned;
         r_illegal    <= w_illegal;
      end else if (OUT_READY) begin
         r_valid      <= 1'b0;
      end else begin
         r_valid      <= r_valid;
      end
   end

   // Performance counters: a clear takes priority, and increments saturate.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_br_cnt <= '0;
         r_mp_cnt <= '0;
      end else if (CNT_CLR) begin
         r_br_cnt <= '0;
         r_mp_cnt <= '0;
      end else if (w_accept) begin
         r_br_cnt <= w_is_cf   ? f_sat_inc(r_br_cnt) : r_br_cnt;
         r_mp_cnt <= w_mispred ? f_sat_inc(r_mp_cnt) : r_mp_cnt;
      end else begin
         r_br_cnt <= r_br_cnt;
         r_mp_cnt <= r_mp_cnt;
      end
   end

   assign OUT_VALID      = r_valid;
   assign OUT_TAKEN      = r_taken;
   assign OUT_TARGET     = r_target;
   assign OUT_LINK       = r_link;
   assign OUT_REDIRECT   = r_redirect;
   assign OUT_MISPREDICT = r_mispred;
   assign OUT_MISALIGNED = r_misaligned;
   assign OUT_ILLEGAL    = r_illegal;
   assign BR_COUNT       = r_br_cnt;
   assign MISPRED_COUNT  = r_mp_cnt;

endmodule

// File: tb/tb_core_branch_unit.sv
// Testbench for core_branch_unit. It applies a table of directed vectors
// and then runs hand-written sequences for stall, flush, counter
// saturation/clear and asynchronous reset.
module tb_core_branch_unit;

   typedef struct {
      logic [1:0]  typ;
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        pt;
      logic [31:0] ptgt;
      logic        e_taken;
      logic [31:0] e_target;
      logic [31:0] e_link;
      logic [31:0] e_redir;
      logic        e_mp;
      logic        e_mis;
      logic        e_ill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        in_ready4;
   logic [1:0]  in_type;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2, pc, imm, pred_target;
   logic        pred_taken;
   logic        out_ready;
   logic        cnt_clr;
   logic        out_valid, out_taken, out_mp, out_mis, out_ill;
   logic [31:0] out_target, out_link, out_redir;
   logic [15:0] br_cnt, mp_cnt;
   logic        out_valid4, out_taken4, out_mp4, out_mis4, out_ill4;
   logic [31:0] out_target4, out_link4, out_redir4;
   logic [3:0]  br_cnt4, mp_cnt4;

   int checks = 0;
   int failures = 0;
   int exp_br = 0;
   int exp_mp = 0;
   vec_t vecs[13];

   always #5 clk = ~clk;

   core_branch_unit #(.XLEN(32), .CNT_W(16)) dut (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_TYPE(in_type), .FUNCT3(funct3), .RS1(rs1), .RS2(rs2), .PC(pc), .IMM(imm),
      .PRED_TAKEN(pred_taken), .PRED_TARGET(pred_target), .OUT_VALID(out_valid),
      .OUT_READY(out_ready), .OUT_TAKEN(out_taken), .OUT_TARGET(out_target),
      .OUT_LINK(out_link), .OUT_REDIRECT(out_redir), .OUT_MISPREDICT(out_mp),
      .OUT_MISALIGNED(out_mis), .OUT_ILLEGAL(out_ill), .CNT_CLR(cnt_clr),
      .BR_COUNT(br_cnt), .MISPRED_COUNT(mp_cnt)
   );

   core_branch_unit #(.XLEN(32), .CNT_W(4)) dut4 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready4),
      .IN_TYPE(in_type), .FUNCT3(funct3), .RS1(rs1), .RS2(rs2), .PC(pc), .IMM(imm),
      .PRED_TAKEN(pred_taken), .PRED_TARGET(pred_target), .OUT_VALID(out_valid4),
      .OUT_READY(out_ready), .OUT_TAKEN(out_taken4), .OUT_TARGET(out_target4),
      .OUT_LINK(out_link4), .OUT_REDIRECT(out_redir4), .OUT_MISPREDICT(out_mp4),
      .OUT_MISALIGNED(out_mis4), .OUT_ILLEGAL(out_ill4), .CNT_CLR(cnt_clr),
      .BR_COUNT(br_cnt4), .MISPRED_COUNT(mp_cnt4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [1:0] typ, input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
      input logic [31:0] p, input logic [31:0] im, input logic t, input logic [31:0] tg,
      input logic e_t, input logic [31:0] e_tg, input logic [31:0] e_l, input logic [31:0] e_r,
      input logic e_m, input logic e_ma, input logic e_il);
      vec_t v;
      v.typ = typ; v.f3 = f3; v.rs1 = r1; v.rs2 = r2; v.pc = p; v.imm = im;
      v.pt = t; v.ptgt = tg; v.e_taken = e_t; v.e_target = e_tg; v.e_link = e_l;
      v.e_redir = e_r; v.e_mp = e_m; v.e_mis = e_ma; v.e_ill = e_il;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      in_type = v.typ; funct3 = v.f3; rs1 = v.rs1; rs2 = v.rs2; pc = v.pc; imm = v.imm;
      pred_taken = v.pt; pred_target = v.ptgt;
   endtask

   task automatic chk_result(input string tag, input vec_t v);
      chk({tag, ".valid"},    64'(out_valid),  64'd1);
      chk({tag, ".taken"},    64'(out_taken),  64'(v.e_taken));
      chk({tag, ".target"},   64'(out_target), 64'(v.e_target));
      chk({tag, ".link"},     64'(out_link),   64'(v.e_link));
      chk({tag, ".redirect"}, 64'(out_redir),  64'(v.e_redir));
      chk({tag, ".mispred"},  64'(out_mp),     64'(v.e_mp));
      chk({tag, ".misalign"}, 64'(out_mis),    64'(v.e_mis));
      chk({tag, ".illegal"},  64'(out_ill),    64'(v.e_ill));
   endtask

   task automatic note_accept(input vec_t v);
      if (v.typ != 2'b00) exp_br++;
      if (v.e_mp) exp_mp++;
   endtask

   initial begin
      //            typ    f3      rs1           rs2           pc            imm           pt    ptgt          tk    target        link          redirect      mp    mis   ill
      vecs[0]  = mk(2'b01, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 1'b0, 32'h00000000, 1'b1, 32'h00000120, 32'h00000104, 32'h00000120, 1'b1, 1'b0, 1'b0);
      vecs[1]  = mk(2'b01, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000100, 32'h00000020, 1'b0, 32'h00000000, 1'b0, 32'h00000120, 32'h00000104, 32'h00000104, 1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(2'b11, 3'b000, 32'h00001003, 32'h00000000, 32'h00000200, 32'h00000004, 1'b1, 32'h00001006, 1'b1, 32'h00001006, 32'h00000204, 32'h00001006, 1'b0, 1'b1, 1'b0);
      vecs[3]  = mk(2'b01, 3'b000, 32'h00000005, 32'h00000005, 32'h00001000, 32'hFFFFFFF0, 1'b1, 32'h00000FF0, 1'b1, 32'h00000FF0, 32'h00001004, 32'h00000FF0, 1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(2'b01, 3'b001, 32'h00000005, 32'h00000005, 32'h00001000, 32'h00000008, 1'b1, 32'h00002000, 1'b0, 32'h00001008, 32'h00001004, 32'h00001004, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(2'b01, 3'b101, 32'h80000000, 32'h00000000, 32'h00000040, 32'h00000010, 1'b0, 32'h00000000, 1'b0, 32'h00000050, 32'h00000044, 32'h00000044, 1'b0, 1'b0, 1'b0);
      vecs[6]  = mk(2'b01, 3'b111, 32'h80000000, 32'h00000000, 32'h00000040, 32'h00000010, 1'b0, 32'h00000000, 1'b1, 32'h00000050, 32'h00000044, 32'h00000050, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(2'b10, 3'b000, 32'h00000000, 32'h00000000, 32'h00000300, 32'h00000100, 1'b1, 32'h00000404, 1'b1, 32'h00000400, 32'h00000304, 32'h00000400, 1'b1, 1'b0, 1'b0);
      vecs[8]  = mk(2'b01, 3'b010, 32'h00000001, 32'h00000001, 32'h00000500, 32'h00000004, 1'b1, 32'h00000000, 1'b0, 32'h00000504, 32'h00000504, 32'h00000504, 1'b1, 1'b0, 1'b1);
      vecs[9]  = mk(2'b00, 3'b000, 32'h00000000, 32'h00000000, 32'h00000600, 32'h00000008, 1'b1, 32'h00000000, 1'b0, 32'h00000608, 32'h00000604, 32'h00000604, 1'b0, 1'b0, 1'b0);
      vecs[10] = mk(2'b01, 3'b000, 32'h00000001, 32'h00000002, 32'hFFFFFFFC, 32'h00000008, 1'b0, 32'h00000000, 1'b0, 32'h00000004, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(2'b01, 3'b100, 32'h00000001, 32'h00000002, 32'h00000010, 32'h00000002, 1'b1, 32'h00000012, 1'b1, 32'h00000012, 32'h00000014, 32'h00000012, 1'b0, 1'b1, 1'b0);
      vecs[12] = mk(2'b11, 3'b011, 32'hFFFFFFFF, 32'h00000000, 32'h00000800, 32'h00000002, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 32'h00000804, 32'h00000000, 1'b0, 1'b0, 1'b0);

      // Reset state
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      apply(vecs[9]);
      #1;
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.in_ready",  64'(in_ready),  64'd1);
      chk("reset.target",    64'(out_target), 64'd0);
      chk("reset.br_count",  64'(br_cnt),    64'd0);
      chk("reset.mp_count",  64'(mp_cnt),    64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         apply(vecs[i]); in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         note_accept(vecs[i]);
         chk_result($sformatf("vec%0d", i), vecs[i]);
      end
      chk("table.br_count",  64'(br_cnt),  64'(exp_br));
      chk("table.mp_count",  64'(mp_cnt),  64'(exp_mp));
      chk("table.br_count4", 64'(br_cnt4), 64'(exp_br));
      chk("table.mp_count4", 64'(mp_cnt4), 64'(exp_mp));

      // Stall: A held for three cycles while B waits, then B enters on the drain cycle
      @(negedge clk);
      apply(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      note_accept(vecs[0]);
      apply(vecs[2]);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("stall%0d.valid", c),    64'(out_valid),  64'd1);
         chk($sformatf("stall%0d.target", c),   64'(out_target), 64'h120);
         chk($sformatf("stall%0d.mispred", c),  64'(out_mp),     64'd1);
         chk($sformatf("stall%0d.in_ready", c), 64'(in_ready),   64'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("stall.drain_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      note_accept(vecs[2]);
      chk_result("stall.B", vecs[2]);
      chk("stall.br_count", 64'(br_cnt), 64'(exp_br));
      chk("stall.mp_count", 64'(mp_cnt), 64'(exp_mp));
      @(negedge clk);
      chk("stall.empty", 64'(out_valid), 64'd0);

      // Flush while full with a same-cycle input
      apply(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      note_accept(vecs[0]);
      chk("flush.pre_valid", 64'(out_valid), 64'd1);
      flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush.valid",    64'(out_valid), 64'd0);
      chk("flush.br_count", 64'(br_cnt),    64'(exp_br));
      chk("flush.mp_count", 64'(mp_cnt),    64'(exp_mp));

      // Counter clear, then 20 mispredicted branches back to back
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      chk("clr.br_count", 64'(br_cnt), 64'd0);
      chk("clr.mp_count", 64'(mp_cnt), 64'd0);
      apply(vecs[0]); in_valid = 1'b1; out_ready = 1'b1;
      repeat (20) @(negedge clk);
      in_valid = 1'b0;
      chk("sat.br_count",  64'(br_cnt),  64'd20);
      chk("sat.mp_count",  64'(mp_cnt),  64'd20);
      chk("sat.br_count4", 64'(br_cnt4), 64'hF);
      chk("sat.mp_count4", 64'(mp_cnt4), 64'hF);

      // Clear with a concurrent acceptance
      @(negedge clk);
      cnt_clr = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0; in_valid = 1'b0;
      chk("clracc.valid",     64'(out_valid), 64'd1);
      chk("clracc.br_count",  64'(br_cnt),    64'd0);
      chk("clracc.mp_count",  64'(mp_cnt),    64'd0);
      chk("clracc.br_count4", 64'(br_cnt4),   64'd0);
      chk("clracc.mp_count4", 64'(mp_cnt4),   64'd0);

      // Asynchronous reset mid-stall with a request pending
      @(negedge clk);
      apply(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("rststall.pre_valid", 64'(out_valid), 64'd1);
      chk("rststall.pre_br",    64'(br_cnt),    64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstasync.valid",    64'(out_valid),  64'd0);
      chk("rstasync.taken",    64'(out_taken),  64'd0);
      chk("rstasync.target",   64'(out_target), 64'd0);
      chk("rstasync.link",     64'(out_link),   64'd0);
      chk("rstasync.mispred",  64'(out_mp),     64'd0);
      chk("rstasync.br_count", 64'(br_cnt),     64'd0);
      chk("rstasync.mp_count", 64'(mp_cnt),     64'd0);
      chk("rstasync.in_ready", 64'(in_ready),   64'd1);
      @(negedge clk);
      chk("rsthold.valid",    64'(out_valid), 64'd0);
      chk("rsthold.br_count", 64'(br_cnt),    64'd0);
      in_valid = 1'b0;
      rst = 1'b0;

      // First request after reset: PC wraps so link and redirect are zero
      apply(vecs[10]); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk_result("postrst", vecs[10]);
      chk("postrst.br_count", 64'(br_cnt), 64'd1);
      chk("postrst.mp_count", 64'(mp_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
